// File: rtl/hamming_tx_if.sv
// ============================================================================
// hamming_tx_if
// Request / result bundle between a Hamming(7,4) transmitter and its user.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hamming_tx_if;
    logic       start;
    logic [3:0] data_in;
    logic [2:0] err_pos;
    logic       busy;
    logic [7:0] word_out;
    logic       word_valid;
    logic       tx_serial;
    logic       tx_bit_valid;
    logic       done;

    modport master (
        output start, data_in, err_pos,
        input  busy, word_out, word_valid, tx_serial, tx_bit_valid, done
    );

    modport slave (
        input  start, data_in, err_pos,
        output busy, word_out, word_valid, tx_serial, tx_bit_valid, done
    );
endinterface

`default_nettype wire

// File: rtl/hamming_tx.sv
// ============================================================================
// hamming_tx
// Hamming(7,4) encoder with optional single-bit error injection, parallel
// word output and MSB-first serialiser.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hamming_tx #(
    parameter int BIT_CYCLES = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hamming_tx_if.slave bus
);

    localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        data_q;
    logic [2:0]        err_q;
    logic [7:0]        word_q;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              word_valid_q;
    logic              last_hold;
    logic              last_bit;

    // Bit 0 is a spare slot kept at 0; injection lands after parity so the
    // receiver's syndrome points straight at err_pos.
    function automatic logic [7:0] encode(input logic [3:0] d, input logic [2:0] e);
        logic [7:0] w;
        w    = 8'h00;
        w[3] = d[3];
        w[5] = d[2];
        w[6] = d[1];
        w[7] = d[0];
        w[1] = w[3] ^ w[5] ^ w[7];
        w[2] = w[3] ^ w[6] ^ w[7];
        w[4] = w[5] ^ w[6] ^ w[7];
        if (e != 3'd0) begin
            w[e] = ~w[e];
        end
        return w;
    endfunction

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign last_bit  = (bit_idx == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_hold && last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= 4'h0;
            err_q        <= 3'd0;
            word_q       <= 8'h00;
            shreg        <= 8'h00;
            bit_idx      <= 3'd0;
            hold_cnt     <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_q <= bus.data_in;
                        err_q  <= bus.err_pos;
                    end
                end
                LOAD: begin
                    word_q       <= encode(data_q, err_q);
                    shreg        <= encode(data_q, err_q);
                    word_valid_q <= 1'b1;
                    bit_idx      <= 3'd7;
                    hold_cnt     <= '0;
                end
                SHIFT: begin
                    if (last_hold) begin
                        hold_cnt <= '0;
                        shreg    <= {shreg[6:0], 1'b0};
                        if (!last_bit) begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line outputs decode straight from state so reset forces them at once.
    assign bus.busy         = (state != IDLE);
    assign bus.word_out     = word_q;
    assign bus.word_valid   = word_valid_q;
    assign bus.tx_bit_valid = (state == SHIFT);
    assign bus.tx_serial    = (state == SHIFT) ? shreg[7] : 1'b1;
    assign bus.done         = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_hamming_tx.sv
// ============================================================================
// tb_hamming_tx
// Directed bench for hamming_tx: fixed vectors plus an all-inputs sweep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hamming_tx;

    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    hamming_tx_if bus ();

    hamming_tx #(.BIT_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Parity bit p covers every position whose index has bit p set.
    function automatic logic [7:0] ref_encode(input logic [3:0] d, input logic [2:0] e);
        logic [7:0] w;
        w = 8'h00;
        w[3] = d[3];
        w[5] = d[2];
        w[6] = d[1];
        w[7] = d[0];
        for (int p = 1; p <= 4; p = p * 2) begin
            for (int j = 3; j <= 7; j++) begin
                if (((j & p) != 0) && (j != p)) w[p] = w[p] ^ w[j];
            end
        end
        if (e != 3'd0) w[e] = ~w[e];
        return w;
    endfunction

    function automatic logic [2:0] syndrome(input logic [7:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int j = 1; j <= 7; j++) begin
            if (w[j]) s = s ^ 3'(j);
        end
        return s;
    endfunction

    function automatic logic [3:0] ref_decode(input logic [7:0] w);
        logic [7:0] c;
        logic [2:0] s;
        c = w;
        s = syndrome(w);
        if (s != 3'd0) c[s] = ~c[s];
        return {c[3], c[5], c[6], c[7]};
    endfunction

    task automatic run_word(input logic [3:0] d, input logic [2:0] e, input logic [7:0] exp,
                            input bit full, input bit poke);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.err_pos = e;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = ~d;
        bus.err_pos = 3'(e + 3'd3);
        if (bus.busy) busy_cnt++;
        if (full) chk("load_word_valid", 8'(bus.word_valid), 8'd0);
        @(negedge clk);
        if (bus.busy) busy_cnt++;
        chk("word_valid", 8'(bus.word_valid), 8'd1);
        chk("word_out", bus.word_out, exp);
        for (int i = 7; i >= 0; i--) begin
            for (int c = 0; c < BC; c++) begin
                if (full) begin
                    chk($sformatf("tx_serial[%0d]", i), 8'(bus.tx_serial), 8'(exp[i]));
                    if (c == 0) chk("tx_bit_valid", 8'(bus.tx_bit_valid), 8'd1);
                    if (i == 7 && c == 1) chk("word_valid_pulse", 8'(bus.word_valid), 8'd0);
                end
                if (poke && i == 4 && c == 1) begin
                    bus.start   = 1'b1;
                    bus.data_in = 4'h0;
                    bus.err_pos = 3'd2;
                end
                if (poke && i == 4 && c == 2) bus.start = 1'b0;
                @(negedge clk);
                if (bus.busy) busy_cnt++;
            end
        end
        if (full) begin
            chk("done", 8'(bus.done), 8'd1);
            chk("done_tx_serial", 8'(bus.tx_serial), 8'd1);
            chk("done_tx_bit_valid", 8'(bus.tx_bit_valid), 8'd0);
        end
        @(negedge clk);
        chk("idle_busy", 8'(bus.busy), 8'd0);
        chk("word_out_held", bus.word_out, exp);
        if (full) begin
            chk("idle_done", 8'(bus.done), 8'd0);
            chk("busy_cycles", 8'(busy_cnt), 8'(2 + 8 * BC));
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = 4'h0;
        bus.err_pos = 3'd0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_word_out", bus.word_out, 8'h00);
        chk("rst_word_valid", 8'(bus.word_valid), 8'd0);
        chk("rst_tx_serial", 8'(bus.tx_serial), 8'd1);
        chk("rst_tx_bit_valid", 8'(bus.tx_bit_valid), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        rst = 1'b0;

        // Hand-computed vectors
        run_word(4'b1011, 3'd0, 8'hCC, 1'b1, 1'b0);
        run_word(4'b1111, 3'd0, 8'hFE, 1'b1, 1'b0);
        run_word(4'b0000, 3'd0, 8'h00, 1'b1, 1'b0);
        run_word(4'b1011, 3'd5, 8'hEC, 1'b1, 1'b0);
        run_word(4'b1011, 3'd1, 8'hCE, 1'b1, 1'b0);

        // Start during SHIFT is dropped, not queued
        run_word(4'b1011, 3'd0, 8'hCC, 1'b1, 1'b1);
        @(negedge clk);
        chk("no_queue_busy", 8'(bus.busy), 8'd0);
        chk("no_queue_word", bus.word_out, 8'hCC);

        // Async reset in the middle of SHIFT
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 4'b1111;
        bus.err_pos = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_tx_bit_valid", 8'(bus.tx_bit_valid), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 8'(bus.busy), 8'd0);
        chk("mid_rst_word_out", bus.word_out, 8'h00);
        chk("mid_rst_tx_serial", 8'(bus.tx_serial), 8'd1);
        chk("mid_rst_tx_bit_valid", 8'(bus.tx_bit_valid), 8'd0);
        chk("mid_rst_done", 8'(bus.done), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", 8'(bus.done), 8'd0);
        end
        run_word(4'b1011, 3'd5, 8'hEC, 1'b1, 1'b0);

        // All data x err_pos combinations
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                run_word(4'(d), 3'(e), ref_encode(4'(d), 3'(e)), 1'b0, 1'b0);
                chk("decode_data", 8'(ref_decode(bus.word_out)), 8'(d));
                chk("decode_syndrome", 8'(syndrome(bus.word_out)), 8'(e));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
